// File: rtl/pin_sample_scanner.sv
// Shared pin-controller bus master: arbitrates host accesses against periodic
// sample scans of all enabled pins and queues the read samples in a FIFO.
//
// state    | meaning
// IDLE     | bus free; grants the host or starts a scan
// HOST     | host transaction on the shared bus
// HOST_ACK | host_ack pulse, read data captured; no new grant
// SCAN     | visiting one pin per bus-free cycle
module pin_sample_scanner #(
    parameter int NUM_PINS   = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_host_req,
    input  logic                          i_host_we,
    input  logic [18:0]                   i_host_addr,
    input  logic [15:0]                   i_host_wdata,
    output logic                          o_host_ack,
    output logic [15:0]                   o_host_rdata,
    output logic [18:0]                   o_bus_addr,
    output logic                          o_bus_wr,
    output logic                          o_bus_rd,
    output logic [15:0]                   o_bus_wdata,
    input  logic [15:0]                   i_bus_rdata,
    input  logic                          i_scan_en,
    input  logic [15:0]                   i_scan_period,
    input  logic [NUM_PINS-1:0]           i_scan_mask,
    output logic                          o_smp_valid,
    input  logic                          i_smp_ready,
    output logic [23:0]                   o_smp_data,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    input  logic                          i_overflow_clr
);

    localparam int              AW         = $clog2(FIFO_DEPTH);
    localparam logic [7:0]      LAST_IDX   = 8'(NUM_PINS - 1);
    localparam logic [AW:0]     FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_HOST, S_HOST_ACK, S_SCAN} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [7:0]      r_idx;
    logic [15:0]     r_cnt;
    logic            r_in_scan;
    logic            r_scan_rd;
    logic [7:0]      r_rd_idx;
    logic [18:0]     r_bus_addr;
    logic            r_bus_wr;
    logic            r_bus_rd;
    logic [15:0]     r_bus_wdata;
    logic [15:0]     r_host_rdata;
    logic [23:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic            r_overflow;

    logic            w_cnt_zero;
    logic            w_last;
    logic            w_scan_go;
    logic            w_visit;
    logic            w_grant;
    logic            w_start;
    logic            w_mask_bit;
    logic            w_full;
    logic            w_pop;
    logic            w_wr_en;
    logic            w_drop;

    assign w_cnt_zero = (r_cnt == 16'd0);
    assign w_last     = (r_idx == LAST_IDX);
    assign w_scan_go  = (r_state == S_SCAN) && !i_host_req;
    assign w_visit    = w_scan_go && i_scan_en;
    assign w_grant    = i_host_req && ((r_state == S_IDLE) || (r_state == S_SCAN));
    // A scan that ends with the period already expired rolls straight into the next one.
    assign w_start    = i_scan_en && w_cnt_zero && !i_host_req &&
                        ((r_state == S_IDLE) || ((r_state == S_SCAN) && w_last));

    always_comb begin
        w_mask_bit = 1'b0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (r_idx == 8'(i)) w_mask_bit = i_scan_mask[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_host_req)   w_next = S_HOST;
                else if (w_start) w_next = S_SCAN;
            end
            S_HOST:     w_next = S_HOST_ACK;
            S_HOST_ACK: w_next = (r_in_scan && i_scan_en) ? S_SCAN : S_IDLE;
            S_SCAN: begin
                if (i_host_req)                w_next = S_HOST;
                else if (!i_scan_en)           w_next = S_IDLE;
                else if (w_last && !w_cnt_zero) w_next = S_IDLE;
            end
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_host_ack = (r_state == S_HOST_ACK);
    end

    // Loading period-1 places consecutive scan starts exactly scan_period cycles apart.
    always_ff @(posedge clk) begin
        if (reset)           r_cnt <= 16'd0;
        else if (w_start)    r_cnt <= (i_scan_period == 16'd0) ? 16'd0 : i_scan_period - 16'd1;
        else if (!w_cnt_zero) r_cnt <= r_cnt - 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx     <= 8'd0;
            r_in_scan <= 1'b0;
        end else begin
            if (w_grant) r_in_scan <= (r_state == S_SCAN);
            if (w_visit)
                r_idx <= w_last ? 8'd0 : r_idx + 8'd1;
            else if (w_scan_go && !i_scan_en)
                r_idx <= 8'd0;
            else if ((r_state == S_HOST_ACK) && !(r_in_scan && i_scan_en))
                r_idx <= 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bus_addr  <= 19'd0;
            r_bus_wr    <= 1'b0;
            r_bus_rd    <= 1'b0;
            r_bus_wdata <= 16'd0;
            r_scan_rd   <= 1'b0;
            r_rd_idx    <= 8'd0;
        end else begin
            r_bus_wr  <= 1'b0;
            r_bus_rd  <= 1'b0;
            r_scan_rd <= 1'b0;
            if (w_grant) begin
                r_bus_addr  <= i_host_addr;
                r_bus_wr    <= i_host_we;
                r_bus_rd    <= !i_host_we;
                r_bus_wdata <= i_host_wdata;
            end else if (w_visit && w_mask_bit) begin
                r_bus_addr <= {3'b000, r_idx, 8'h07};
                r_bus_rd   <= 1'b1;
                r_scan_rd  <= 1'b1;
                r_rd_idx   <= r_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                             r_host_rdata <= 16'd0;
        else if ((r_state == S_HOST) && r_bus_rd) r_host_rdata <= i_bus_rdata;
    end

    assign w_full  = (r_level == FULL_LEVEL);
    assign w_pop   = (r_level != '0) && i_smp_ready;
    assign w_wr_en = r_scan_rd && (!w_full || w_pop);
    assign w_drop  = r_scan_rd && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) r_mem[r_wr_ptr] <= {r_rd_idx, i_bus_rdata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)   r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + (AW + 1)'(1);
                2'b01:   r_level <= r_level - (AW + 1)'(1);
                default: r_level <= r_level;
            endcase
            // A drop wins over a simultaneous clear so no lost sample goes unreported.
            if (w_drop)              r_overflow <= 1'b1;
            else if (i_overflow_clr) r_overflow <= 1'b0;
        end
    end

    assign o_host_rdata = r_host_rdata;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_wr     = r_bus_wr;
    assign o_bus_rd     = r_bus_rd;
    assign o_bus_wdata  = r_bus_wdata;
    assign o_smp_valid  = (r_level != '0);
    assign o_smp_data   = r_mem[r_rd_ptr];
    assign o_fifo_level = r_level;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_pin_sample_scanner.sv
// Self-checking bench for pin_sample_scanner: host vector table, scan scoreboard,
// and hand-written sequences for preemption, overflow, scan abort and reset.
module tb_pin_sample_scanner;

    localparam int NUM_PINS   = 8;
    localparam int FIFO_DEPTH = 16;

    typedef struct {
        logic        we;
        logic [18:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } host_vec_t;

    logic          clk;
    logic          reset;
    logic          host_req;
    logic          host_we;
    logic [18:0]   host_addr;
    logic [15:0]   host_wdata;
    logic          host_ack;
    logic [15:0]   host_rdata;
    logic [18:0]   bus_addr;
    logic          bus_wr;
    logic          bus_rd;
    logic [15:0]   bus_wdata;
    logic [15:0]   bus_rdata;
    logic          scan_en;
    logic [15:0]   scan_period;
    logic [7:0]    scan_mask;
    logic          smp_valid;
    logic          smp_ready;
    logic [23:0]   smp_data;
    logic [4:0]    fifo_level;
    logic          overflow;
    logic          overflow_clr;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    int            rd_count = 0;
    int            sb_rd    = 0;
    int            base;
    logic [23:0]   exp_q[$];
    int            start_q[$];
    host_vec_t     host_tbl[4];

    pin_sample_scanner #(.NUM_PINS(NUM_PINS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr),
        .i_host_wdata(host_wdata), .o_host_ack(host_ack), .o_host_rdata(host_rdata),
        .o_bus_addr(bus_addr), .o_bus_wr(bus_wr), .o_bus_rd(bus_rd),
        .o_bus_wdata(bus_wdata), .i_bus_rdata(bus_rdata),
        .i_scan_en(scan_en), .i_scan_period(scan_period), .i_scan_mask(scan_mask),
        .o_smp_valid(smp_valid), .i_smp_ready(smp_ready), .o_smp_data(smp_data),
        .o_fifo_level(fifo_level), .o_overflow(overflow), .i_overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pin controllers answer idx+1 at their sample register; other addresses return addr^A5A5.
    always_comb begin
        bus_rdata = 16'h0000;
        if (bus_rd) begin
            if (bus_addr[18:16] == 3'b000 && bus_addr[7:0] == 8'h07)
                bus_rdata = {8'h00, bus_addr[15:8]} + 16'd1;
            else
                bus_rdata = bus_addr[15:0] ^ 16'hA5A5;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observes the current cycle with inputs final, then advances to the next negedge+1.
    task automatic step();
        if (!reset) begin
            if (smp_valid && smp_ready) begin
                if (sb_rd < exp_q.size()) begin
                    check("smp_data", {8'h00, smp_data}, {8'h00, exp_q[sb_rd]});
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL smp_unexpected: got 0x%0h expected no entry (cycle %0d)", smp_data, cyc);
                end
                sb_rd++;
            end
            if (bus_rd && bus_addr[18:16] == 3'b000 && bus_addr[7:0] == 8'h07) begin
                rd_count++;
                if (bus_addr[15:8] == 8'h00) start_q.push_back(cyc);
            end
            if (bus_rd && bus_wr) begin
                checks++;
                failures++;
                $display("FAIL bus_both: got wr=1 rd=1 expected at most one (cycle %0d)", cyc);
            end
        end
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_scan(input logic [7:0] mask);
        for (int p = 0; p < NUM_PINS; p++)
            if (mask[p]) exp_q.push_back({8'(p), 16'(p + 1)});
    endtask

    task automatic wait_read(input int pin, input int n, input int bound, input string name);
        int seen = 0;
        int k = 0;
        while (seen < n && k < bound) begin
            step();
            k++;
            if (bus_rd && bus_addr == {3'b000, 8'(pin), 8'h07}) seen++;
        end
        check(name, seen, n);
    endtask

    task automatic do_host(input host_vec_t v);
        int k = 0;
        host_req   = 1'b1;
        host_we    = v.we;
        host_addr  = v.addr;
        host_wdata = v.wdata;
        do begin
            step();
            k++;
        end while (!((bus_wr || bus_rd) && bus_addr[7:0] != 8'h07) && k < 10);
        check("host_grant_lat", k, 1);
        check("host_bus_addr", bus_addr, v.addr);
        check("host_bus_wr", bus_wr, v.we);
        check("host_bus_rd", bus_rd, !v.we);
        if (v.we) check("host_bus_wdata", bus_wdata, v.wdata);
        check("host_ack_early", host_ack, 0);
        step();
        check("host_ack", host_ack, 1);
        check("host_rdata", host_rdata, v.exp_rdata);
        check("host_ack_bus_idle", {bus_wr, bus_rd}, 2'b00);
        host_req = 1'b0;
        step();
        check("host_ack_pulse", host_ack, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_host_ack"}, host_ack, 0);
        check({tag, "_host_rdata"}, host_rdata, 0);
        check({tag, "_bus_wr"}, bus_wr, 0);
        check({tag, "_bus_rd"}, bus_rd, 0);
        check({tag, "_bus_addr"}, bus_addr, 0);
        check({tag, "_bus_wdata"}, bus_wdata, 0);
        check({tag, "_smp_valid"}, smp_valid, 0);
        check({tag, "_fifo_level"}, fifo_level, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = '0;
        host_wdata   = '0;
        scan_en      = 1'b0;
        scan_period  = '0;
        scan_mask    = '0;
        smp_ready    = 1'b0;
        overflow_clr = 1'b0;
        exp_q.delete();
        sb_rd = 0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    initial begin
        host_tbl[0] = '{we: 1'b1, addr: 19'h00105, wdata: 16'h0003, exp_rdata: 16'h0000};
        host_tbl[1] = '{we: 1'b0, addr: 19'h00105, wdata: 16'h0000, exp_rdata: 16'hA4A0};
        host_tbl[2] = '{we: 1'b1, addr: 19'h7FFFF, wdata: 16'hFFFF, exp_rdata: 16'hA4A0};
        host_tbl[3] = '{we: 1'b0, addr: 19'h00200, wdata: 16'h1234, exp_rdata: 16'hA7A5};

        do_reset();
        step();
        check_reset_outputs("rst");

        for (int i = 0; i < 4; i++) begin
            do_host(host_tbl[i]);
            step();
        end

        // Periodic scan, mask A5, two scans 100 cycles apart
        do_reset();
        scan_mask   = 8'hA5;
        scan_period = 16'd100;
        smp_ready   = 1'b1;
        push_scan(8'hA5);
        push_scan(8'hA5);
        base = rd_count;
        start_q.delete();
        scan_en = 1'b1;
        repeat (150) step();
        scan_en = 1'b0;
        repeat (20) step();
        check("period_reads", rd_count - base, 8);
        check("period_starts", start_q.size(), 2);
        if (start_q.size() == 2) check("period_spacing", start_q[1] - start_q[0], 100);
        check("period_sb_done", sb_rd, exp_q.size());

        // Host preempts the scan with pin 3 next
        do_reset();
        scan_mask   = 8'hFF;
        scan_period = 16'd1000;
        smp_ready   = 1'b1;
        push_scan(8'hFF);
        base = rd_count;
        scan_en = 1'b1;
        wait_read(2, 1, 20, "preempt_wait_pin2");
        do_host(host_tbl[1]);
        repeat (20) step();
        scan_en = 1'b0;
        step();
        check("preempt_reads", rd_count - base, 8);
        check("preempt_sb_done", sb_rd, exp_q.size());

        // Overflow: three back-to-back scans into a stalled FIFO
        do_reset();
        scan_mask   = 8'hFF;
        scan_period = 16'd0;
        push_scan(8'hFF);
        push_scan(8'hFF);
        scan_en = 1'b1;
        wait_read(7, 3, 100, "ovf_wait_reads");
        scan_en = 1'b0;
        repeat (2) step();
        check("ovf_level_full", fifo_level, 16);
        check("ovf_sticky", overflow, 1);
        check("ovf_valid", smp_valid, 1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("ovf_cleared", overflow, 0);
        scan_mask = 8'h01;
        scan_en   = 1'b1;
        wait_read(0, 1, 20, "ovf_wait_pushpop");
        smp_ready = 1'b1;
        scan_en   = 1'b0;
        exp_q.push_back({8'd0, 16'd1});
        step();
        smp_ready = 1'b0;
        check("pushpop_level", fifo_level, 16);
        step();
        check("pushpop_no_drop", overflow, 0);
        smp_ready = 1'b1;
        repeat (20) step();
        check("drain_level", fifo_level, 0);
        check("drain_valid", smp_valid, 0);
        check("drain_sb_done", sb_rd, exp_q.size());

        // scan_en drops while pin 4 is being read
        do_reset();
        scan_mask   = 8'hFF;
        scan_period = 16'd1000;
        smp_ready   = 1'b1;
        push_scan(8'h1F);
        base = rd_count;
        scan_en = 1'b1;
        wait_read(4, 1, 20, "abort_wait_pin4");
        scan_en = 1'b0;
        repeat (15) step();
        check("abort_reads", rd_count - base, 5);
        check("abort_sb_done", sb_rd, exp_q.size());
        check("abort_level", fifo_level, 0);

        // Reset while the host transaction is on the bus
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 19'h00105;
        host_wdata = 16'h0003;
        step();
        check("rstmid_bus_wr", bus_wr, 1);
        reset = 1'b1;
        step();
        check_reset_outputs("rstmid");
        host_req = 1'b0;
        step();
        check("rstmid_no_ack", host_ack, 0);
        reset = 1'b0;
        repeat (3) step();
        check("rstmid_idle_ack", host_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
